// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and constants for the FIFO frame writer
package fifo_pkg;

  // Writer sequencing: intake states first, then the four emit states
  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    DISCARD,
    HEADER,
    PAYLOAD,
    CHECKSUM,
    FLUSH
  } writerState;

  // Each emitted beat is issued once, then checked against the FIFO halt
  typedef enum logic {
    ISSUE,
    CHECK
  } beatPhase;

  // Trailing beat that makes the FIFO commit the checksum
  localparam logic [7:0] FLUSH_BYTE = 8'h00;

  // True while the writer is pushing beats into the FIFO
  function automatic logic isEmitState(input writerState s);
    return (s == HEADER) || (s == PAYLOAD) || (s == CHECKSUM) || (s == FLUSH);
  endfunction

  // True while the writer can take upstream bytes
  function automatic logic isIntakeState(input writerState s);
    return (s == IDLE) || (s == COLLECT) || (s == DISCARD);
  endfunction

endpackage

// File: rtl/fifo_frame_writer_frame_buffer.sv
// rtl/fifo_frame_writer_frame_buffer.sv - frame payload store with byte count and running XOR
module frame_buffer #(
  parameter  int MAX_LEN = 16,
  localparam int CW      = $clog2(MAX_LEN + 1)
) (
  input  logic          Clk,
  input  logic          reset,
  input  logic          wrEn,
  input  logic          wrFirst,
  input  logic [7:0]    wrData,
  input  logic [CW-1:0] rdIdx,
  output logic [7:0]    rdData,
  output logic [CW-1:0] count,
  output logic [7:0]    checksum
);

  logic [7:0]    mem [MAX_LEN];
  logic [CW-1:0] wrIdx;

  // The first byte of a frame restarts the buffer at slot 0
  assign wrIdx = wrFirst ? '0 : count;

  // Payload storage; contents are don't-care until rewritten, so no reset
  always_ff @(posedge Clk) begin
    for (int i = 0; i < MAX_LEN; i++) begin
      if (wrEn && (wrIdx == CW'(i))) begin
        mem[i] <= wrData;
      end
    end
  end

  // Read mux by explicit compare so the index width never has to match the depth
  always_comb begin
    rdData = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (rdIdx == CW'(i)) begin
        rdData = mem[i];
      end
    end
  end

  // Byte count and XOR of the payload bytes seen so far in this frame
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      checksum <= '0;
    end else if (wrEn) begin
      if (wrFirst) begin
        count    <= CW'(1);
        checksum <= wrData;
      end else begin
        count    <= count + CW'(1);
        checksum <= checksum ^ wrData;
      end
    end
  end

endmodule

// File: rtl/fifo_frame_writer.sv
// rtl/fifo_frame_writer.sv - buffers one upstream frame and pushes it into the async FIFO write port
module fifo_frame_writer
  import fifo_pkg::*;
#(
  parameter int MAX_LEN      = 16,
  parameter int HALT_TIMEOUT = 255
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       inValid,
  output logic       inReady,
  input  logic [7:0] inData,
  input  logic       inLast,
  output logic       fifoControl,
  output logic [7:0] fifoData,
  input  logic       fifoHalt,
  output logic       busy,
  output logic       frameDone,
  output logic       overflowErr,
  output logic       timeoutErr
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int HW = $clog2(HALT_TIMEOUT + 1);

  writerState    state, nextState;
  beatPhase      phase, nextPhase;
  logic [CW-1:0] len, nextLen;
  logic [CW-1:0] rdIdx, nextRdIdx;
  logic [HW-1:0] haltCnt, nextHaltCnt;
  logic          nextFrameDone, nextOverflowErr, nextTimeoutErr;

  logic          bufWrEn, bufWrFirst;
  logic [7:0]    bufRdData, bufChecksum;
  logic [CW-1:0] bufCount;
  logic [7:0]    len8;
  logic          take;

  assign take = inValid && inReady;
  assign len8 = 8'(len);

  frame_buffer #(
    .MAX_LEN (MAX_LEN)
  ) frameBuffer (
    .Clk      (Clk),
    .reset    (reset),
    .wrEn     (bufWrEn),
    .wrFirst  (bufWrFirst),
    .wrData   (inData),
    .rdIdx    (rdIdx),
    .rdData   (bufRdData),
    .count    (bufCount),
    .checksum (bufChecksum)
  );

  // State register plus the frame length, read index, halt counter and event pulses
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      phase       <= ISSUE;
      len         <= '0;
      rdIdx       <= '0;
      haltCnt     <= '0;
      frameDone   <= 1'b0;
      overflowErr <= 1'b0;
      timeoutErr  <= 1'b0;
    end else begin
      state       <= nextState;
      phase       <= nextPhase;
      len         <= nextLen;
      rdIdx       <= nextRdIdx;
      haltCnt     <= nextHaltCnt;
      frameDone   <= nextFrameDone;
      overflowErr <= nextOverflowErr;
      timeoutErr  <= nextTimeoutErr;
    end
  end

  // Next-state logic: intake, overflow drop, and the issue/check handshake per beat
  always_comb begin
    nextState       = state;
    nextPhase       = phase;
    nextLen         = len;
    nextRdIdx       = rdIdx;
    nextHaltCnt     = haltCnt;
    nextFrameDone   = 1'b0;
    nextOverflowErr = 1'b0;
    nextTimeoutErr  = 1'b0;
    bufWrEn         = 1'b0;
    bufWrFirst      = 1'b0;

    case (state)
      IDLE: begin
        if (take) begin
          bufWrEn    = 1'b1;
          bufWrFirst = 1'b1;
          if (inLast) begin
            nextState   = HEADER;
            nextLen     = CW'(1);
            nextPhase   = ISSUE;
            nextRdIdx   = '0;
            nextHaltCnt = '0;
          end else begin
            nextState = COLLECT;
          end
        end
      end

      COLLECT: begin
        if (take) begin
          if (bufCount == CW'(MAX_LEN)) begin
            // No room for this byte: drop the whole frame
            nextOverflowErr = 1'b1;
            nextState       = inLast ? IDLE : DISCARD;
          end else begin
            bufWrEn = 1'b1;
            if (inLast) begin
              nextState   = HEADER;
              nextLen     = bufCount + CW'(1);
              nextPhase   = ISSUE;
              nextRdIdx   = '0;
              nextHaltCnt = '0;
            end
          end
        end
      end

      DISCARD: begin
        if (take && inLast) begin
          nextState = IDLE;
        end
      end

      HEADER, PAYLOAD, CHECKSUM, FLUSH: begin
        if (phase == ISSUE) begin
          nextPhase = CHECK;
        end else if (!fifoHalt) begin
          // Beat accepted: move on to the next beat of the frame
          nextPhase   = ISSUE;
          nextHaltCnt = '0;
          case (state)
            HEADER: begin
              nextState = PAYLOAD;
              nextRdIdx = '0;
            end
            PAYLOAD: begin
              if (rdIdx == len - CW'(1)) begin
                nextState = CHECKSUM;
                nextRdIdx = '0;
              end else begin
                nextRdIdx = rdIdx + CW'(1);
              end
            end
            CHECKSUM: nextState = FLUSH;
            FLUSH: begin
              nextState     = IDLE;
              nextFrameDone = 1'b1;
            end
            default: nextState = IDLE;
          endcase
        end else if (haltCnt >= HW'(HALT_TIMEOUT - 1)) begin
          // This refusal is the last one tolerated: abandon the frame
          nextState      = IDLE;
          nextPhase      = ISSUE;
          nextHaltCnt    = '0;
          nextTimeoutErr = 1'b1;
        end else begin
          // Refused: count it and re-issue the same beat
          nextPhase   = ISSUE;
          nextHaltCnt = (haltCnt == HW'(HALT_TIMEOUT)) ? haltCnt : haltCnt + HW'(1);
        end
      end

      default: begin
        nextState = IDLE;
        nextPhase = ISSUE;
      end
    endcase
  end

  // Outputs: upstream ready, beat mux and FIFO write strobe; ready is forced low while in reset
  always_comb begin
    inReady     = reset && isIntakeState(state);
    busy        = (state != IDLE);
    fifoControl = isEmitState(state) && (phase == ISSUE);
    case (state)
      HEADER:   fifoData = len8;
      PAYLOAD:  fifoData = bufRdData;
      CHECKSUM: fifoData = len8 ^ bufChecksum;
      FLUSH:    fifoData = FLUSH_BYTE;
      default:  fifoData = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_fifo_frame_writer.sv
// tb/tb_fifo_frame_writer.sv - randomized scoreboard bench for fifo_frame_writer
module tb_fifo_frame_writer;

  localparam int MAX_LEN = 16;
  localparam int HALT_TO = 4;

  typedef logic [7:0] byteQ[$];

  logic       Clk = 1'b0;
  logic       reset = 1'b0;
  logic       inValid = 1'b0;
  logic [7:0] inData = 8'h00;
  logic       inLast = 1'b0;
  logic       fifoHalt = 1'b0;
  logic       inReady, fifoControl, busy, frameDone, overflowErr, timeoutErr;
  logic [7:0] fifoData;

  fifo_frame_writer #(
    .MAX_LEN      (MAX_LEN),
    .HALT_TIMEOUT (HALT_TO)
  ) dut (
    .Clk         (Clk),
    .reset       (reset),
    .inValid     (inValid),
    .inReady     (inReady),
    .inData      (inData),
    .inLast      (inLast),
    .fifoControl (fifoControl),
    .fifoData    (fifoData),
    .fifoHalt    (fifoHalt),
    .busy        (busy),
    .frameDone   (frameDone),
    .overflowErr (overflowErr),
    .timeoutErr  (timeoutErr)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int passes = 0;

  logic [7:0] expQ[$];
  int  issues = 0, accepted = 0, doneCnt = 0, ovfCnt = 0, toCnt = 0;
  int  haltMode = 0;
  int  streak = 0;
  bit  haltB2Done = 0;
  bit  pending = 0;
  bit  prevCtl = 0;
  logic [7:0] pendData = 8'h00;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual, expected, expected);
  endtask

  // Reference frame on the FIFO: length, payload, XOR of all previous bytes, flush zero
  task automatic pushExp(input byteQ f);
    logic [7:0] x;
    x = 8'(f.size());
    expQ.push_back(8'(f.size()));
    foreach (f[i]) begin
      expQ.push_back(f[i]);
      x = x ^ f[i];
    end
    expQ.push_back(x);
    expQ.push_back(8'h00);
  endtask

  // FIFO model and monitor: records issued beats, drives halt, scores accepted beats
  always @(negedge Clk) begin
    if (!reset) begin
      pending  = 0;
      fifoHalt = 1'b0;
      prevCtl  = 0;
    end else begin
      if (frameDone) doneCnt++;
      if (overflowErr) ovfCnt++;
      if (timeoutErr) toCnt++;
      if (frameDone || overflowErr || timeoutErr)
        check("pulse_exclusive", int'(frameDone) + int'(overflowErr) + int'(timeoutErr), 1);
      if (fifoControl) check("ctl_not_consecutive", int'(prevCtl), 0);
      if (pending) begin
        pending = 0;
        check("data_held", fifoData, pendData);
        if (!fifoHalt) begin
          streak = 0;
          accepted++;
          if (expQ.size() == 0) begin
            checks++;
            $display("FAIL beat_unexpected: got 0x%02h expected no beat", pendData);
          end else begin
            check("beat", pendData, expQ.pop_front());
          end
        end else begin
          streak++;
        end
      end else if (fifoControl) begin
        issues++;
        pendData = fifoData;
        pending  = 1;
        case (haltMode)
          1: fifoHalt = (streak < 2) && ($urandom_range(0, 2) == 0);
          2: fifoHalt = 1'b1;
          3: begin
            fifoHalt = (fifoData == 8'hB2) && !haltB2Done;
            if (fifoData == 8'hB2) haltB2Done = 1;
          end
          default: fifoHalt = 1'b0;
        endcase
      end else begin
        fifoHalt = 1'b0;
      end
      prevCtl = fifoControl;
    end
  end

  task automatic settle();
    @(posedge Clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] d, input bit last, output int waited);
    inValid = 1'b1;
    inData  = d;
    inLast  = last;
    waited  = 0;
    @(negedge Clk);
    while (!inReady && waited < 1000) begin
      waited++;
      @(negedge Clk);
    end
    if (!inReady) check("send_ready_timeout", 0, 1);
    @(posedge Clk);
    #1;
    inValid = 1'b0;
    inLast  = 1'b0;
  endtask

  task automatic sendFrame(input byteQ f);
    int w;
    foreach (f[i]) sendByte(f[i], i == f.size() - 1, w);
  endtask

  task automatic waitDone(input int target);
    int n = 0;
    while (doneCnt < target && n < 3000) begin
      @(posedge Clk);
      n++;
    end
    #1;
    check("frame_done", doneCnt, target);
  endtask

  initial begin
    byteQ f, f2;
    int i0, d0, o0, t0, a0, w, totalWait, n, len;

    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    check("rst_inReady", inReady, 0);
    check("rst_busy", busy, 0);
    check("rst_fifoControl", fifoControl, 0);
    check("rst_fifoData", fifoData, 0);
    check("rst_frameDone", frameDone, 0);
    check("rst_overflowErr", overflowErr, 0);
    check("rst_timeoutErr", timeoutErr, 0);
    reset = 1'b1;
    settle();
    check("idle_inReady", inReady, 1);
    check("idle_busy", busy, 0);

    // Plain 3-byte frame, no back-pressure
    haltMode = 0;
    f = '{8'hA1, 8'hB2, 8'hC3};
    i0 = issues; d0 = doneCnt;
    pushExp(f);
    sendFrame(f);
    waitDone(d0 + 1);
    repeat (3) settle();
    check("t1_issues", issues - i0, 6);
    check("t1_done", doneCnt - d0, 1);
    check("t1_drained", expQ.size(), 0);

    // Same frame with one refusal of B2
    haltMode = 3; haltB2Done = 0;
    i0 = issues; d0 = doneCnt;
    pushExp(f);
    sendFrame(f);
    waitDone(d0 + 1);
    repeat (3) settle();
    check("t2_issues", issues - i0, 7);
    check("t2_drained", expQ.size(), 0);

    // Overflow: 17 bytes without last, then a few more ending with last
    haltMode = 0;
    i0 = issues; o0 = ovfCnt; totalWait = 0;
    for (int i = 0; i < MAX_LEN + 1; i++) begin
      sendByte(8'($urandom), 1'b0, w);
      totalWait += w;
    end
    settle();
    check("t3_overflow_pulse", ovfCnt - o0, 1);
    check("t3_discard_busy", busy, 1);
    for (int i = 0; i < 3; i++) begin
      sendByte(8'($urandom), i == 2, w);
      totalWait += w;
    end
    repeat (2) settle();
    check("t3_never_stalled", totalWait, 0);
    check("t3_no_fifo", issues - i0, 0);
    check("t3_idle", busy, 0);
    check("t3_single_pulse", ovfCnt - o0, 1);

    // Halt held from the header until timeout
    haltMode = 2;
    i0 = issues; t0 = toCnt; d0 = doneCnt;
    f = '{8'h11, 8'h22};
    sendFrame(f);
    n = 0;
    while (toCnt == t0 && n < 500) begin
      @(posedge Clk);
      n++;
    end
    repeat (2) settle();
    check("t4_timeout_pulse", toCnt - t0, 1);
    check("t4_header_issues", issues - i0, HALT_TO);
    check("t4_idle", busy, 0);
    check("t4_inReady", inReady, 1);
    check("t4_no_done", doneCnt - d0, 0);
    haltMode = 0;
    settle();

    // Reset dropped during payload, then a 1-byte frame
    f = {};
    for (int i = 0; i < 4; i++) f.push_back(8'($urandom));
    pushExp(f);
    a0 = accepted;
    sendFrame(f);
    n = 0;
    while (accepted - a0 < 2 && n < 500) begin
      @(posedge Clk);
      n++;
    end
    #2;
    check("t5_busy_before", busy, 1);
    reset = 1'b0;
    #1;
    check("t5_rst_fifoControl", fifoControl, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_inReady", inReady, 0);
    expQ.delete();
    settle();
    reset = 1'b1;
    settle();
    i0 = issues; d0 = doneCnt;
    expQ.push_back(8'h01);
    expQ.push_back(8'h5A);
    expQ.push_back(8'h5B);
    expQ.push_back(8'h00);
    f = '{8'h5A};
    sendFrame(f);
    waitDone(d0 + 1);
    repeat (2) settle();
    check("t5_issues", issues - i0, 4);
    check("t5_drained", expQ.size(), 0);

    // Back-to-back frames under random back-pressure
    haltMode = 1; streak = 0;
    d0 = doneCnt;
    f = '{8'($urandom), 8'($urandom)};
    f2 = '{8'($urandom)};
    pushExp(f);
    pushExp(f2);
    sendFrame(f);
    sendFrame(f2);
    waitDone(d0 + 2);
    repeat (2) settle();
    check("t6_drained", expQ.size(), 0);

    // Random-length frames, including the maximum length
    for (int k = 0; k < 6; k++) begin
      len = (k == 0) ? MAX_LEN : $urandom_range(1, MAX_LEN);
      f = {};
      for (int i = 0; i < len; i++) f.push_back(8'($urandom));
      d0 = doneCnt;
      pushExp(f);
      sendFrame(f);
      waitDone(d0 + 1);
    end
    repeat (3) settle();
    check("t7_drained", expQ.size(), 0);
    check("t7_idle", busy, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
